instr_cache_dm: RTL and testbench
=================================

Name: instr_cache_dm

Overview:
- Direct-mapped, multi-word-line instruction cache between the CPU fetch stage and the MCB-style main-memory port.
- Replaces the single-word fetch path with parametrised burst line fills.
- Hits return an instruction combinationally in the same cycle.
- Adds a whole-cache invalidate for self-modifying code and program reload.

Parameters:
ADDR_BITS, 16, byte-address width of instr_ptr
INSTR_BITS, 32, instruction width (one memory word)
LINE_WORDS, 8, words per line; power of 2, range 2..64
NUM_LINES, 16, lines in the cache; power of 2, at least 2
MEM_PREFIX, 30-ADDR_BITS bits of 0, upper bits of mem_cmd_byte_addr

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
boot_done  in  1  high once the bootloader has filled RAM; level signal
instr_ptr  in  ADDR_BITS  byte address requested; bits [1:0] ignored
invalidate  in  1  single-cycle pulse; clear all line valid bits
valid  out  1  instr holds the word at instr_ptr this cycle
instr  out  INSTR_BITS  fetched instruction
mem_cmd_en  out  1  command strobe, one cycle per fill
mem_cmd_instr  out  3  constant 3'b001 (read)
mem_cmd_bl  out  6  constant LINE_WORDS-1
mem_cmd_byte_addr  out  30  {MEM_PREFIX, line-aligned instr_ptr}
mem_cmd_full  in  1  command FIFO full
mem_rd_en  out  1  read-FIFO pop
mem_rd_data  in  32  read data, first-word-fall-through
mem_rd_empty  in  1  read FIFO empty

Behaviour:
- Address split of instr_ptr, with W = log2(LINE_WORDS) and I = log2(NUM_LINES):
  - offset = [W+1:2]
  - index = [W+I+1:W+2]
  - tag = [ADDR_BITS-1:W+I+2]
- Storage:
  - data array: NUM_LINES*LINE_WORDS x INSTR_BITS, asynchronous read
  - tag array: NUM_LINES x tag width
  - valid vector: NUM_LINES flops
- Reset (asynchronous, reset_n low):
  - state = PRE_BOOT; all valid bits = 0
  - mem_cmd_en = 0, mem_rd_en = 0, mem_cmd_byte_addr = 0, fill counter = 0, pending-invalidate = 0
  - instr follows the data array (undefined contents); valid = 0
  - Reset mid-fill abandons the fill. The memory FIFO is not drained; the integrator resets the MCB port alongside this block.
- Outputs:
  - valid = (state == IDLE) and valid[index] and (tag array[index] == tag).
  - instr = data[index, offset], combinational. Zero-latency hit.
- States:
  - PRE_BOOT:
    - Stay while boot_done = 0.
    - When boot_done = 1, go to IDLE.
  - IDLE:
    - On hit, stay.
    - On miss, latch the line address (tag, index) and go to CMD.
    - Invalidate and a miss in the same cycle: invalidate wins. Clear all valid bits, stay in IDLE, and re-evaluate next cycle.
  - CMD:
    - If mem_cmd_full = 1, hold. mem_cmd_en stays 0.
    - Otherwise pulse mem_cmd_en for one cycle, with mem_cmd_byte_addr = {MEM_PREFIX, tag, index, W+2 zero bits}. Clear the fill counter and go to FILL.
  - FILL:
    - Each cycle with mem_rd_empty = 0: mem_rd_en = 1 (combinational), write mem_rd_data to data[latched index, counter], and increment the counter.
    - When the word at counter = LINE_WORDS-1 is written: write the tag and set valid[index] = 1, unless pending-invalidate is set. Then go to IDLE.
    - The cycle after the last word is the first possible hit.
- invalidate during CMD or FILL:
  - Sets pending-invalidate.
  - On fill completion: all valid bits cleared, the filled line is NOT marked valid, pending cleared.
- instr_ptr changing during CMD or FILL is ignored. The latched line completes, then IDLE re-evaluates.
- Fill-to-refetch latency for an uncontended miss: at least LINE_WORDS + 2 cycles plus memory latency.
- Line replacement is unconditional overwrite (direct-mapped).

Optional Feature:
- Macro: INSTR_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments each IDLE cycle with valid = 1 and instr_ptr different from the previous cycle's instr_ptr (counts unique fetches).
  - miss_count increments on each IDLE to CMD transition.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on reset_n only; invalidate does not clear them.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Cold miss, default parameters:
  - Stimulus: boot_done=1, instr_ptr=16'h0010.
  - Response: one mem_cmd_en with mem_cmd_byte_addr=30'h0000, mem_cmd_bl=7.
  - Feed 8 words 32'hA000_0000+k: 8 mem_rd_en pulses, then valid=1 with instr=32'hA000_0004.
- Hit sweep:
  - Stimulus: instr_ptr 16'h0000..16'h001C step 4 after the fill.
  - Response: valid=1 every cycle, no mem_cmd_en, instr = the matching word.
- Conflict eviction:
  - Stimulus: after the line-0 fill, instr_ptr=16'h0200 (same index, new tag).
  - Response: fill at byte_addr 30'h0200. Then a return to 16'h0000 misses again.
- Backpressure:
  - Stimulus: mem_cmd_full=1 for 5 cycles at a miss.
  - Response: mem_cmd_en stays 0, then pulses once when full drops.
  - Stimulus: mem_rd_empty toggled every other cycle.
  - Response: mem_rd_en only in non-empty cycles, exactly 8 pops.
- Invalidate:
  - Stimulus: pulse invalidate mid-fill (after word 3).
  - Response: the fill finishes (8 pops), valid stays 0, the same address re-fetches.
  - Stimulus: invalidate in IDLE on a hitting line.
  - Response: valid=0 next cycle, then a new miss.
- Reset and stats:
  - Stimulus: reset_n low mid-fill.
  - Response: immediately mem_rd_en=0, valid=0, state PRE_BOOT.
  - With INSTR_CACHE_STATS_EN defined, after the 8-hit sweep: hit_count=8, miss_count=1.

Source files
------------

// File: rtl/instr_cache_dm.sv
// Direct-mapped instruction cache with burst line fills from an MCB-style read port.
// Optional hit/miss counters when INSTR_CACHE_STATS_EN is defined.
module instr_cache_dm #(
   parameter int unsigned           ADDR_BITS  = 16,
   parameter int unsigned           INSTR_BITS = 32,
   parameter int unsigned           LINE_WORDS = 8,
   parameter int unsigned           NUM_LINES  = 16,
   parameter logic [29-ADDR_BITS:0] MEM_PREFIX = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  boot_done,
   input  logic [ADDR_BITS-1:0]  instr_ptr,
   input  logic                  invalidate,
   output logic                  valid,
   output logic [INSTR_BITS-1:0] instr,
   output logic                  mem_cmd_en,
   output logic [2:0]            mem_cmd_instr,
   output logic [5:0]            mem_cmd_bl,
   output logic [29:0]           mem_cmd_byte_addr,
   input  logic                  mem_cmd_full,
   output logic                  mem_rd_en,
   input  logic [31:0]           mem_rd_data,
   input  logic                  mem_rd_empty
`ifdef INSTR_CACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int unsigned W        = $clog2(LINE_WORDS);
   localparam int unsigned I        = $clog2(NUM_LINES);
   localparam int unsigned TAG_BITS = ADDR_BITS - W - I - 2;

   typedef enum logic [1:0] {PRE_BOOT, IDLE, CMD, FILL} state_t;

   state_t                state_q, state_d;
   logic [NUM_LINES-1:0]  vbits_q, vbits_d;
   logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;
   logic [I-1:0]          line_idx_q, line_idx_d;
   logic [W-1:0]          cnt_q, cnt_d;
   logic                  pend_inv_q, pend_inv_d;
   logic                  data_we, tag_we;

   logic [INSTR_BITS-1:0] data_mem [NUM_LINES*LINE_WORDS];
   logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];

   logic [W-1:0]          offset;
   logic [I-1:0]          index;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;
   logic                  unused_ptr_bits;

   assign offset          = instr_ptr[W+1:2];
   assign index           = instr_ptr[W+I+1:W+2];
   assign tag             = instr_ptr[ADDR_BITS-1:W+I+2];
   assign unused_ptr_bits = ^instr_ptr[1:0];

   assign hit   = vbits_q[index] && (tag_mem[index] == tag);
   assign valid = (state_q == IDLE) && hit;
   assign instr = data_mem[{index, offset}];

   assign mem_cmd_instr     = 3'b001;
   assign mem_cmd_bl        = 6'(LINE_WORDS - 1);
   assign mem_cmd_byte_addr = {MEM_PREFIX, line_tag_q, line_idx_q, {(W+2){1'b0}}};

   always_comb begin
      state_d    = state_q;
      vbits_d    = vbits_q;
      line_tag_d = line_tag_q;
      line_idx_d = line_idx_q;
      cnt_d      = cnt_q;
      pend_inv_d = pend_inv_q;
      mem_cmd_en = 1'b0;
      mem_rd_en  = 1'b0;
      data_we    = 1'b0;
      tag_we     = 1'b0;
      unique case (state_q)
         PRE_BOOT: begin
            if (invalidate) vbits_d = '0;
            if (boot_done)  state_d = IDLE;
         end
         IDLE: begin
            if (invalidate) begin
               vbits_d = '0;
            end else if (!hit) begin
               line_tag_d = tag;
               line_idx_d = index;
               state_d    = CMD;
            end
         end
         CMD: begin
            if (invalidate) pend_inv_d = 1'b1;
            if (!mem_cmd_full) begin
               mem_cmd_en = 1'b1;
               cnt_d      = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (invalidate) pend_inv_d = 1'b1;
            if (!mem_rd_empty) begin
               mem_rd_en = 1'b1;
               data_we   = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == W'(LINE_WORDS - 1)) begin
                  // An invalidate landing on the last word still discards the line.
                  if (pend_inv_q || invalidate) begin
                     vbits_d = '0;
                  end else begin
                     tag_we              = 1'b1;
                     vbits_d[line_idx_q] = 1'b1;
                  end
                  pend_inv_d = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = PRE_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= PRE_BOOT;
         vbits_q    <= '0;
         line_tag_q <= '0;
         line_idx_q <= '0;
         cnt_q      <= '0;
         pend_inv_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vbits_q    <= vbits_d;
         line_tag_q <= line_tag_d;
         line_idx_q <= line_idx_d;
         cnt_q      <= cnt_d;
         pend_inv_q <= pend_inv_d;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) data_mem[{line_idx_q, cnt_q}] <= INSTR_BITS'(mem_rd_data);
      if (tag_we)  tag_mem[line_idx_q]           <= line_tag_q;
   end

`ifdef INSTR_CACHE_STATS_EN
   logic [ADDR_BITS-1:0] prev_ptr_q;
   logic [31:0]          hit_cnt_q, hit_cnt_d;
   logic [31:0]          miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (valid && (instr_ptr != prev_ptr_q) && (hit_cnt_q != '1))
         hit_cnt_d = hit_cnt_q + 1'b1;
      if ((state_q == IDLE) && (state_d == CMD) && (miss_cnt_q != '1))
         miss_cnt_d = miss_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_ptr_q <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         prev_ptr_q <= instr_ptr;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache_dm.sv
// Self-checking bench for instr_cache_dm: MCB read-port model, command scoreboard,
// table-driven hit sweep and hand-written miss/backpressure/invalidate/reset sequences.
module tb_instr_cache_dm;

   logic        clk = 1'b0;
   logic        reset_n, boot_done, invalidate, mem_cmd_full, mem_rd_empty;
   logic [15:0] instr_ptr;
   logic        valid;
   logic [31:0] instr;
   logic        mem_cmd_en;
   logic [2:0]  mem_cmd_instr;
   logic [5:0]  mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rd_data;
`ifdef INSTR_CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   instr_cache_dm dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .boot_done         (boot_done),
      .instr_ptr         (instr_ptr),
      .invalidate        (invalidate),
      .valid             (valid),
      .instr             (instr),
      .mem_cmd_en        (mem_cmd_en),
      .mem_cmd_instr     (mem_cmd_instr),
      .mem_cmd_bl        (mem_cmd_bl),
      .mem_cmd_byte_addr (mem_cmd_byte_addr),
      .mem_cmd_full      (mem_cmd_full),
      .mem_rd_en         (mem_rd_en),
      .mem_rd_data       (mem_rd_data),
      .mem_rd_empty      (mem_rd_empty)
`ifdef INSTR_CACHE_STATS_EN
      ,
      .hit_count         (hit_count),
      .miss_count        (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   int          cmd_cnt = 0, pop_cnt = 0, empty_pop = 0;
   logic [31:0] gen = 0;
   bit          throttle = 0, thr = 0;
   logic [31:0] rdq [$];
   logic [29:0] exp_cmd_q [$];
   logic [31:0] exp_instr_q [$];

   typedef struct {
      logic [15:0] ptr;
      logic        vld;
      logic [31:0] instr;
   } vec_t;
   vec_t sweep [8];

   function automatic logic [31:0] word_at(input logic [29:0] a, input logic [31:0] g);
      return 32'hA000_0000 + g * 32'h0100_0000 + 32'(a >> 2);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!valid) begin
         checks++;
         failures++;
         $display("FAIL %s: valid never rose within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_pops(input int target, input string name);
      int n = 0;
      while (pop_cnt < target && n < 100) begin
         cyc();
         n++;
      end
      if (pop_cnt < target) begin
         checks++;
         failures++;
         $display("FAIL %s: pops got %0d expected %0d", name, pop_cnt, target);
      end
   endtask

   // Memory-port model: accepts commands, serves the FWFT read FIFO.
   initial begin
      mem_rd_empty = 1'b1;
      mem_rd_data  = '0;
      forever begin
         bit pop;
         @(negedge clk);
         if (mem_cmd_en) begin
            cmd_cnt++;
            if (exp_cmd_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL cmd_unexpected: got addr %0h expected no command", mem_cmd_byte_addr);
            end else begin
               check("cmd_addr", 64'(mem_cmd_byte_addr), 64'(exp_cmd_q.pop_front()));
            end
            check("cmd_bl", 64'(mem_cmd_bl), 64'd7);
            check("cmd_instr", 64'(mem_cmd_instr), 64'd1);
            for (int k = 0; k < 8; k++)
               rdq.push_back(word_at(mem_cmd_byte_addr + 30'(4 * k), gen));
         end
         pop = mem_rd_en;
         if (pop) pop_cnt++;
         if (pop && mem_rd_empty) empty_pop++;
         @(posedge clk);
         #1;
         if (!reset_n) rdq.delete();
         else if (pop && rdq.size() > 0) void'(rdq.pop_front());
         thr = ~thr;
         mem_rd_empty = (rdq.size() == 0) || (throttle && thr);
         mem_rd_data  = (rdq.size() > 0) ? rdq[0] : '0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int c0, p0;
      for (int i = 0; i < 8; i++) begin
         sweep[i].ptr   = 16'(4 * i);
         sweep[i].vld   = 1'b1;
         sweep[i].instr = 32'hA000_0000 + 32'(i);
      end

      reset_n = 1'b0; boot_done = 1'b0; invalidate = 1'b0;
      mem_cmd_full = 1'b0; instr_ptr = 16'h0010;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_rd_en", 64'(mem_rd_en), 64'd0);
      check("rst_cmd_en", 64'(mem_cmd_en), 64'd0);
      check("rst_cmd_addr", 64'(mem_cmd_byte_addr), 64'd0);
      cyc(); reset_n = 1'b1;
      repeat (4) cyc();
      @(negedge clk);
      check("preboot_no_cmd", 64'(cmd_cnt), 64'd0);
      check("preboot_valid", 64'(valid), 64'd0);

      // cold miss
      cyc(); boot_done = 1'b1; exp_cmd_q.push_back(30'h0);
      wait_valid(100, "cold_fill");
      check("cold_cmds", 64'(cmd_cnt), 64'd1);
      check("cold_pops", 64'(pop_cnt), 64'd8);
      check("cold_instr", 64'(instr), 64'hA000_0004);

      // hit sweep
      for (int i = 0; i < 8; i++) begin
         cyc();
         instr_ptr = sweep[i].ptr;
         exp_instr_q.push_back(sweep[i].instr);
         @(negedge clk);
         check("sweep_valid", 64'(valid), 64'(sweep[i].vld));
         check("sweep_instr", 64'(instr), 64'(exp_instr_q.pop_front()));
      end
      check("sweep_no_cmd", 64'(cmd_cnt), 64'd1);
`ifdef INSTR_CACHE_STATS_EN
      cyc();
      @(negedge clk);
      check("stats_hits", 64'(hit_count), 64'd8);
      check("stats_misses", 64'(miss_count), 64'd1);
`endif

      // conflict eviction and return
      cyc(); instr_ptr = 16'h0200; exp_cmd_q.push_back(30'h200);
      @(negedge clk);
      check("evict_miss", 64'(valid), 64'd0);
      wait_valid(100, "evict_fill");
      check("evict_instr", 64'(instr), 64'hA000_0080);
      cyc(); instr_ptr = 16'h0000; exp_cmd_q.push_back(30'h0);
      @(negedge clk);
      check("return_miss", 64'(valid), 64'd0);
      wait_valid(100, "return_fill");
      check("return_instr", 64'(instr), 64'hA000_0000);
      check("return_cmds", 64'(cmd_cnt), 64'd3);

      // command backpressure
      cyc(); instr_ptr = 16'h0400; mem_cmd_full = 1'b1; exp_cmd_q.push_back(30'h400);
      c0 = cmd_cnt;
      repeat (5) begin
         @(negedge clk);
         check("full_no_cmd_en", 64'(mem_cmd_en), 64'd0);
      end
      cyc(); mem_cmd_full = 1'b0;
      @(negedge clk);
      check("full_release_cmd_en", 64'(mem_cmd_en), 64'd1);
      wait_valid(100, "full_fill");
      check("full_one_cmd", 64'(cmd_cnt), 64'(c0 + 1));
      check("full_instr", 64'(instr), 64'(word_at(30'h400, 0)));

      // read FIFO throttled every other cycle
      cyc(); throttle = 1'b1; instr_ptr = 16'h0604; exp_cmd_q.push_back(30'h600);
      p0 = pop_cnt;
      wait_valid(200, "throttle_fill");
      check("throttle_pops", 64'(pop_cnt), 64'(p0 + 8));
      check("throttle_empty_pops", 64'(empty_pop), 64'd0);
      check("throttle_instr", 64'(instr), 64'(word_at(30'h604, 0)));

      // invalidate mid-fill: fill completes, line discarded, refetched
      cyc(); throttle = 1'b0; instr_ptr = 16'h0800;
      exp_cmd_q.push_back(30'h800); exp_cmd_q.push_back(30'h800);
      p0 = pop_cnt; c0 = cmd_cnt;
      wait_pops(p0 + 3, "midfill_pops");
      invalidate = 1'b1; gen = 1;
      cyc(); invalidate = 1'b0;
      wait_valid(200, "midfill_refetch");
      check("midfill_pops_total", 64'(pop_cnt), 64'(p0 + 16));
      check("midfill_cmds", 64'(cmd_cnt), 64'(c0 + 2));
      check("midfill_instr", 64'(instr), 64'(word_at(30'h800, 1)));

      // invalidate in IDLE on a hitting line
      c0 = cmd_cnt;
      cyc(); invalidate = 1'b1; gen = 2; exp_cmd_q.push_back(30'h800);
      @(negedge clk);
      check("inv_idle_same_cycle", 64'(valid), 64'd1);
      cyc(); invalidate = 1'b0;
      @(negedge clk);
      check("inv_idle_next", 64'(valid), 64'd0);
      wait_valid(100, "inv_idle_refill");
      check("inv_idle_cmds", 64'(cmd_cnt), 64'(c0 + 1));
      check("inv_idle_instr", 64'(instr), 64'(word_at(30'h800, 2)));

      // reset mid-fill
      cyc(); instr_ptr = 16'h0A00; exp_cmd_q.push_back(30'hA00);
      p0 = pop_cnt;
      wait_pops(p0 + 2, "rstfill_pops");
      reset_n = 1'b0; boot_done = 1'b0;
      #1;
      check("rstfill_rd_en", 64'(mem_rd_en), 64'd0);
      check("rstfill_valid", 64'(valid), 64'd0);
      check("rstfill_cmd_en", 64'(mem_cmd_en), 64'd0);
      repeat (2) cyc();
      reset_n = 1'b1;
      c0 = cmd_cnt;
      repeat (4) cyc();
      @(negedge clk);
      check("rstfill_preboot_cmds", 64'(cmd_cnt), 64'(c0));
      check("rstfill_preboot_valid", 64'(valid), 64'd0);
      cyc(); boot_done = 1'b1; gen = 3; exp_cmd_q.push_back(30'hA00);
      wait_valid(100, "rstfill_refill");
      check("rstfill_cmds", 64'(cmd_cnt), 64'(c0 + 1));
      check("rstfill_instr", 64'(instr), 64'(word_at(30'hA00, 3)));
`ifdef INSTR_CACHE_STATS_EN
      check("stats_rst_hits", 64'(hit_count), 64'd0);
      check("stats_rst_misses", 64'(miss_count), 64'd1);
`endif
      check("cmd_scoreboard_drained", 64'(exp_cmd_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
